// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: access owner tags and the per-stage pipeline tag.
// PIX_LAT is the fixed cycle count from x,y (or host grant) to registered output.
package vram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_HOST
  } owner_t;

  typedef struct packed {
    owner_t own;
    logic   we;
    logic   in_range;
  } pipe_tag_t;

  localparam int PIX_LAT = 3;

endpackage

// File: rtl/vram_addr_gen.sv
// Raster-to-image mapping: image window hit test and linear image address.
// Purely combinational; the board renderer reuses it for hit testing.
module vram_addr_gen #(
  parameter int unsigned HRES   = 640,
  parameter int unsigned VRES   = 480,
  parameter int unsigned IMG_X0 = 36,
  parameter int unsigned IMG_Y0 = 91,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 18
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic              in_win,
  output logic [ADDR_W-1:0] vaddr
);

  logic [31:0] xw;
  logic [31:0] yw;

  assign xw = 32'(x);
  assign yw = 32'(y);

  assign in_win = (xw >= IMG_X0) && (xw < IMG_X0 + IMG_W) &&
                  (yw >= IMG_Y0) && (yw < IMG_Y0 + IMG_H) &&
                  (xw < HRES) && (yw < VRES);

  // Only meaningful while in_win; outside the window the value is ignored.
  assign vaddr = ADDR_W'(yw - IMG_Y0) * ADDR_W'(IMG_W) + ADDR_W'(xw - IMG_X0);

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port image RAM between the VGA pixel path (absolute priority)
// and a host req/gnt port; pixel and host read data return 3 cycles after issue.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned HRES   = 640,
  parameter int unsigned VRES   = 480,
  parameter int unsigned IMG_X0 = 36,
  parameter int unsigned IMG_Y0 = 91,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 18,
  parameter logic [7:0]  BG_PIX = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [7:0]        pix_data,
  output logic              pix_in_img,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  output logic              host_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_q
);

  logic              in_win;
  logic [ADDR_W-1:0] vaddr;
  logic              in_range;

  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic              mem_we_d, mem_we_q;
  logic [7:0]        mem_wdata_d, mem_wdata_q;
  pipe_tag_t         tag1_d, tag1_q;
  pipe_tag_t         tag2_d, tag2_q;
  logic [7:0]        pix_data_d, pix_data_q;
  logic              pix_in_img_d, pix_in_img_q;
  logic              host_rvalid_d, host_rvalid_q;
  logic [7:0]        host_rdata_d, host_rdata_q;

  vram_addr_gen #(
    .HRES  (HRES),
    .VRES  (VRES),
    .IMG_X0(IMG_X0),
    .IMG_Y0(IMG_Y0),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .x     (x),
    .y     (y),
    .in_win(in_win),
    .vaddr (vaddr)
  );

  assign in_range = 32'(host_addr) < IMG_W * IMG_H;

  // Host only gets the RAM on cycles the raster is outside the image window.
  assign host_gnt = !rst && !in_win && host_req;
  assign host_err = host_gnt && !in_range;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    tag1_d      = '{own: OWN_NONE, we: 1'b0, in_range: 1'b0};
    if (in_win) begin
      mem_addr_d = vaddr;
      tag1_d     = '{own: OWN_VGA, we: 1'b0, in_range: 1'b1};
    end else if (host_gnt) begin
      mem_addr_d  = host_addr;
      mem_we_d    = host_we && in_range;
      mem_wdata_d = host_wdata;
      tag1_d      = '{own: OWN_HOST, we: host_we, in_range: in_range};
    end

    tag2_d        = tag1_q;
    pix_in_img_d  = (tag2_q.own == OWN_VGA);
    pix_data_d    = pix_in_img_d ? mem_q : BG_PIX;
    host_rvalid_d = (tag2_q.own == OWN_HOST) && !tag2_q.we;
    host_rdata_d  = host_rdata_q;
    if (host_rvalid_d) begin
      host_rdata_d = tag2_q.in_range ? mem_q : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'h00;
      tag1_q        <= '{own: OWN_NONE, we: 1'b0, in_range: 1'b0};
      tag2_q        <= '{own: OWN_NONE, we: 1'b0, in_range: 1'b0};
      pix_data_q    <= BG_PIX;
      pix_in_img_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= 8'h00;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      pix_data_q    <= pix_data_d;
      pix_in_img_q  <= pix_in_img_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign pix_data    = pix_data_q;
  assign pix_in_img  = pix_in_img_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed + random bench for vram_arbiter with a behavioural RAM and a shadow-memory reference.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int NCYC = 3000;
  localparam int NRND = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic [7:0]  pix_data;
  logic        pix_in_img;
  logic        host_req, host_we;
  logic [17:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt, host_rvalid, host_err;
  logic [7:0]  host_rdata;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_q;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .pix_data(pix_data), .pix_in_img(pix_in_img),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    if (i == 0) return 8'h5A;
    return 8'((i * 37) ^ ((i >> 8) * 11));
  endfunction

  // Image RAM: single port, registered read, read-before-write.
  logic [7:0] ram [0:262143];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 262144; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_q <= ram[mem_addr];
    end
  end

  // Reference model state
  logic [7:0]  shadow [0:65535];
  logic [7:0]  e_pix  [0:NCYC+7];
  bit          e_img  [0:NCYC+7];
  bit          e_rv   [0:NCYC+7];
  logic [7:0]  e_rd   [0:NCYC+7];
  logic [17:0] m_addr;
  bit          m_we;
  logic [7:0]  m_wd;
  bit          armed;
  bit          rst_prev;
  int          cyc;
  int          n_assert;
  int          n_fail;

  function automatic bit in_window(input int xi, input int yi);
    return xi >= 36 && xi < 36 + 256 && yi >= 91 && yi < 91 + 256 && xi < 640 && yi < 480;
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step(input bit r, input int xi, input int yi, input bit rq, input bit we,
                      input logic [17:0] a, input logic [7:0] wd, output bit g);
    bit w;
    bit inr;
    int va;
    @(negedge clk);
    rst = r; x = 10'(xi); y = 10'(yi);
    host_req = rq; host_we = we; host_addr = a; host_wdata = wd;
    #1;
    w   = in_window(xi, yi);
    inr = (int'(a) < 65536);
    va  = (yi - 91) * 256 + (xi - 36);
    g   = !r && !w && rq;

    chk("host_gnt", 18'(host_gnt), 18'(g));
    chk("host_err", 18'(host_err), 18'(g && !inr));
    if (armed) begin
      chk("pix_data", 18'(pix_data), 18'(e_pix[cyc]));
      chk("pix_in_img", 18'(pix_in_img), 18'(e_img[cyc]));
      chk("host_rvalid", 18'(host_rvalid), 18'(e_rv[cyc]));
      if (e_rv[cyc]) chk("host_rdata", 18'(host_rdata), 18'(e_rd[cyc]));
      chk("mem_we", 18'(mem_we), 18'(m_we));
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", 18'(mem_wdata), 18'(m_wd));
      if (rst_prev) begin
        chk("rst_rdata", 18'(host_rdata), 18'h0);
        chk("rst_wdata", 18'(mem_wdata), 18'h0);
      end
    end

    rst_prev = r;
    if (r) begin
      for (int k = 1; k <= PIX_LAT; k++) begin
        e_pix[cyc+k] = 8'hFF; e_img[cyc+k] = 1'b0; e_rv[cyc+k] = 1'b0;
      end
      m_addr = '0; m_we = 1'b0; m_wd = 8'h00;
      armed = 1'b1;
    end else if (w) begin
      e_pix[cyc+PIX_LAT] = shadow[va];
      e_img[cyc+PIX_LAT] = 1'b1;
      m_addr = 18'(va); m_we = 1'b0;
    end else if (rq) begin
      if (!we) begin
        e_rv[cyc+PIX_LAT] = 1'b1;
        e_rd[cyc+PIX_LAT] = inr ? shadow[int'(a)] : 8'h00;
      end else if (inr) begin
        shadow[int'(a)] = wd;
      end
      m_addr = a; m_we = we && inr; m_wd = wd;
    end else begin
      m_we = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) step(1'b0, 600, 10, 1'b0, 1'b0, 18'h0, 8'h00, g);
  endtask

  initial begin
    bit g;
    bit pend;
    bit pwe;
    logic [17:0] paddr;
    logic [7:0]  pwd;
    int xi, yi, sel;

    n_assert = 0; n_fail = 0; cyc = 0; armed = 1'b0; rst_prev = 1'b0;
    m_addr = '0; m_we = 1'b0; m_wd = 8'h00;
    for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
    for (int i = 0; i < NCYC + 8; i++) begin
      e_pix[i] = 8'hFF; e_img[i] = 1'b0; e_rv[i] = 1'b0; e_rd[i] = 8'h00;
    end
    rst = 1'b1; x = '0; y = '0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Reset with a held request, then release at (0,0)
    step(1'b1, 0, 0, 1'b1, 1'b0, 18'h10, 8'h00, g);
    step(1'b1, 0, 0, 1'b1, 1'b0, 18'h10, 8'h00, g);
    step(1'b0, 0, 0, 1'b1, 1'b0, 18'h10, 8'h00, g);
    // VGA fetches at window origin and (1,1)
    step(1'b0, 36, 91, 1'b0, 1'b0, 18'h0, 8'h00, g);
    step(1'b0, 37, 92, 1'b0, 1'b0, 18'h0, 8'h00, g);
    idle(3);
    // Collision inside window, then grant outside it
    step(1'b0, 100, 100, 1'b1, 1'b0, 18'h1234, 8'h00, g);
    step(1'b0, 300, 100, 1'b1, 1'b0, 18'h1234, 8'h00, g);
    // Write then read of the same address
    step(1'b0, 600, 10, 1'b1, 1'b1, 18'h10, 8'hC3, g);
    step(1'b0, 600, 10, 1'b1, 1'b0, 18'h10, 8'h00, g);
    idle(3);
    // Out-of-range write and read
    step(1'b0, 600, 10, 1'b1, 1'b1, 18'd65536, 8'hAA, g);
    step(1'b0, 600, 10, 1'b1, 1'b0, 18'd65536, 8'h00, g);
    idle(3);
    // Reset one cycle after a read grant
    step(1'b0, 600, 10, 1'b1, 1'b0, 18'h10, 8'h00, g);
    step(1'b1, 600, 10, 1'b0, 1'b0, 18'h0, 8'h00, g);
    idle(4);

    // Random traffic: host holds each request until granted
    pend = 1'b0; pwe = 1'b0; paddr = '0; pwd = '0;
    for (int i = 0; i < NRND; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        pwe  = 1'($urandom_range(0, 1));
        pwd  = 8'($urandom);
        sel  = int'($urandom_range(0, 9));
        if (sel < 6)      paddr = 18'($urandom_range(0, 31));
        else if (sel < 8) paddr = 18'($urandom_range(0, 65535));
        else              paddr = 18'($urandom_range(65536, 262143));
      end
      if ($urandom_range(0, 1) == 0) begin
        xi = int'($urandom_range(20, 310)); yi = int'($urandom_range(80, 360));
      end else begin
        xi = int'($urandom_range(0, 1023)); yi = int'($urandom_range(0, 1023));
      end
      step(($urandom_range(0, 149) == 0), xi, yi, pend, pwe, paddr, pwd, g);
      if (g) pend = 1'b0;
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port 8-bit image RAM (18-bit address, 1-cycle registered read) between two requesters.
- Requester 1 is the VGA pixel path, which has hard real-time priority. Requester 2 is a host/loader port (processor or image loader) with a req/gnt handshake.
- Converts raster coordinates (x,y) into image addresses and returns grayscale pixel data with fixed latency.
- Sits between the VGA timing generator / board renderer and the image memory; the board renderer consumes pix_data/pix_in_img.

Parameters:
- HRES, 640, active horizontal resolution.
- VRES, 480, active vertical resolution.
- IMG_X0, 36, left column of the image window.
- IMG_Y0, 91, top row of the image window.
- IMG_W, 256, image width in pixels.
- IMG_H, 256, image height in pixels (IMG_W*IMG_H ≤ 2^ADDR_W).
- ADDR_W, 18, memory address width.
- BG_PIX, 8'hFF, pixel value returned outside the image window.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- x  in  10  current raster column.
- y  in  10  current raster row.
- pix_data  out  8  grayscale pixel, valid 3 cycles after x,y.
- pix_in_img  out  1  pixel lies inside the image window; aligned with pix_data.
- host_req  in  1  host access request; level, held until granted.
- host_we  in  1  1=write, 0=read; sampled with host_req.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  8  host write data.
- host_gnt  out  1  1-cycle pulse: request accepted this cycle.
- host_rvalid  out  1  1-cycle pulse: host read data valid.
- host_rdata  out  8  host read data.
- host_err  out  1  1-cycle pulse with host_gnt when host_addr is out of range.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  8  RAM write data (registered).
- mem_q  in  8  RAM read data; valid 1 cycle after mem_addr.

Behaviour:
- Window test (cycle 0, combinational): in_win = x∈[IMG_X0, IMG_X0+IMG_W−1] and y∈[IMG_Y0, IMG_Y0+IMG_H−1] and x<HRES and y<VRES.
- Address arithmetic: vaddr = (y−IMG_Y0)*IMG_W + (x−IMG_X0), computed in ADDR_W bits; no wrap is possible inside the window.
- Per-cycle owner select (stage 0), registered into stage 1 as tag ∈ {OWN_NONE, OWN_VGA, OWN_HOST}:
  - in_win=1: OWN_VGA. mem_addr<=vaddr, mem_we<=0. The VGA side always wins, including on simultaneous host_req.
  - else host_req=1: OWN_HOST. host_gnt=1 (combinational from the stage-0 decision, same cycle). mem_addr<=host_addr, mem_we<=host_we & in_range, mem_wdata<=host_wdata.
  - else: OWN_NONE, mem_we<=0, mem_addr holds.
- in_range = host_addr < IMG_W*IMG_H. An out-of-range request is still granted (no hang); host_err pulses with host_gnt; the write is suppressed; a read returns 8'h00.
- Pipeline: stage 1 = memory access, stage 2 = mem_q valid, stage 3 = registered outputs. The tag and in_range bit travel with the access.
- Stage 3, tag OWN_VGA: pix_data<=mem_q, pix_in_img<=1.
- Stage 3, other tags: pix_data<=BG_PIX, pix_in_img<=0.
- Stage 3, tag OWN_HOST with read: host_rvalid<=1 and host_rdata<=mem_q (8'h00 if out of range). Read latency is 3 cycles from the host_gnt cycle.
- Host ordering: strictly in-order; back-to-back grants are allowed every cycle outside the window. A host write followed by a read of the same address returns the new data.
- No preemption: the host waits for the next cycle outside the window. There is no timeout; starvation during an image row is expected and bounded by IMG_W cycles.
- Reset (synchronous, takes effect mid-pipeline):
  - all tags -> OWN_NONE; in-flight host reads are discarded (no host_rvalid).
  - pix_data=BG_PIX, pix_in_img=0.
  - host_gnt=0, host_rvalid=0, host_rdata=0, host_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - A request held across reset is granted on the first eligible cycle after rst falls.
- host_gnt is never asserted while rst=1.

Decomposition:
- Package vram_pkg holds:
  - typedef owner_t enum {OWN_NONE, OWN_VGA, OWN_HOST};
  - struct pipe_tag_t {owner_t own; logic we; logic in_range;};
  - constant PIX_LAT=3.
- One sub-module: vram_addr_gen (window test + vaddr computation, purely combinational), reused by the board renderer for hit testing.

Test Plan:
- Reset: rst held 2 cycles with host_req=1 -> host_gnt=0, mem_we=0, pix_data=8'hFF throughout; after release with x=0,y=0 -> host_gnt=1 next cycle.
- VGA fetch: x=36,y=91 -> mem_addr=0 in cycle 1. x=37,y=92 -> mem_addr=257. With mem_q=8'h5A, pix_data=8'h5A and pix_in_img=1 exactly 3 cycles after x,y.
- Priority collision: x=100,y=100 with host_req=1 -> host_gnt=0. Then x=300 -> host_gnt=1, and the following cycle's mem_addr=host_addr.
- Host write-then-read: outside window, write addr 18'h10 data 8'hC3, then read 18'h10 -> mem_we=1 once; host_rvalid pulses 3 cycles after the read grant with host_rdata=8'hC3.
- Out of range: host write to 65536 -> host_gnt=1, host_err=1, mem_we=0. A read of 65536 -> host_rdata=8'h00.
- Reset mid-read: grant a read, assert rst one cycle later -> no host_rvalid pulse; outputs at reset values.
